// File: rtl/alu_serial_pkg.sv
// ============================================================================
// Module : alu_serial_pkg
// Brief  : Op encodings, FSM state encodings and helpers for the serial ALU.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package alu_serial_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] ALU_AND  = 3'd0;
    localparam logic [OP_W-1:0] ALU_OR   = 3'd1;
    localparam logic [OP_W-1:0] ALU_ADD  = 3'd2;
    localparam logic [OP_W-1:0] ALU_SUB  = 3'd3;
    localparam logic [OP_W-1:0] ALU_XOR  = 3'd4;
    localparam logic [OP_W-1:0] ALU_SLT  = 3'd5;
    localparam logic [OP_W-1:0] ALU_SLTU = 3'd6;
    localparam logic [OP_W-1:0] ALU_RSVD = 3'd7;

    localparam int ST_W = 2;

    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_BUSY = 2'd1;
    localparam logic [ST_W-1:0] ST_DONE = 2'd2;

    // Subtract-style ops run as a + ~b + 1.
    function automatic logic op_inverts_b(input logic [OP_W-1:0] op);
        return (op == ALU_SUB) || (op == ALU_SLT) || (op == ALU_SLTU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_serial_slice.sv
// ============================================================================
// Module : alu_serial_slice
// Brief  : Combinational SLICE-bit ALU slice with ripple carry.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_serial_slice
    import alu_serial_pkg::*;
#(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] i_a,
    input  logic [SLICE-1:0] i_b,
    input  logic             i_cin,
    input  logic [OP_W-1:0]  i_op,
    output logic [SLICE-1:0] o_r,
    output logic             o_cout,
    output logic             o_cmsb
);

    logic [SLICE-1:0] w_bx;
    logic [SLICE-1:0] w_sum;
    logic             w_c;

    assign w_bx = op_inverts_b(i_op) ? ~i_b : i_b;

    // o_cmsb is the carry into the top bit; with o_cout it yields signed overflow.
    always_comb begin
        w_c    = i_cin;
        w_sum  = '0;
        o_cmsb = 1'b0;
        for (int i = 0; i < SLICE; i++) begin
            if (i == SLICE - 1) o_cmsb = w_c;
            w_sum[i] = i_a[i] ^ w_bx[i] ^ w_c;
            w_c      = (i_a[i] & w_bx[i]) | (w_c & (i_a[i] ^ w_bx[i]));
        end
        o_cout = w_c;
    end

    always_comb begin
        o_r = '0;
        case (i_op)
            ALU_AND:                             o_r = i_a & i_b;
            ALU_OR:                              o_r = i_a | i_b;
            ALU_XOR:                             o_r = i_a ^ i_b;
            ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU: o_r = w_sum;
            default:                             o_r = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_serial.sv
// ============================================================================
// Module : alu_serial
// Brief  : Digit-serial ALU, SLICE bits per clock, valid/ready on both sides.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_serial
    import alu_serial_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [OP_W-1:0]  op_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o,
    output logic             overflow_o,
    output logic             zero_o,
    output logic             negative_o
);

    localparam int c_div    = (SLICE < 1) ? 1 : SLICE;
    localparam int c_nslice = WIDTH / c_div;
    localparam int c_cnt_w  = (c_nslice > 1) ? $clog2(c_nslice) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_nslice - 1);

    if ((SLICE < 1) || ((WIDTH % c_div) != 0)) begin : g_bad_cfg
        $error("alu_serial: WIDTH must be a non-zero multiple of SLICE");
    end

    logic [ST_W-1:0]    r_state;
    logic [ST_W-1:0]    w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [OP_W-1:0]    r_op;
    logic               r_cy;
    logic [WIDTH-1:0]   r_res;
    logic               r_carry;
    logic               r_ovf;
    logic               r_zero;
    logic               r_neg;

    logic [SLICE-1:0]   w_r;
    logic               w_cout;
    logic               w_cmsb;
    logic [WIDTH-1:0]   w_full;
    logic [WIDTH-1:0]   w_fin;
    logic               w_c_fin;
    logic               w_v_fin;
    logic               w_in_acc;
    logic               w_out_acc;
    logic               w_last;

    assign w_in_acc  = in_valid_i & in_ready_o;
    assign w_out_acc = out_valid_o & out_ready_i;
    assign w_last    = (r_cnt == c_last);

    alu_serial_slice #(.SLICE(SLICE)) u_slice (
        .i_a    (r_a[SLICE-1:0]),
        .i_b    (r_b[SLICE-1:0]),
        .i_cin  (r_cy),
        .i_op   (r_op),
        .o_r    (w_r),
        .o_cout (w_cout),
        .o_cmsb (w_cmsb)
    );

    // New slices enter at the top so the LSB-first stream ends up aligned.
    if (c_nslice > 1) begin : g_multi
        assign w_full = {w_r, r_res[WIDTH-1:SLICE]};
    end else begin : g_single
        assign w_full = w_r;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_in_acc)  w_state_nxt = ST_BUSY;
            ST_BUSY: if (w_last)    w_state_nxt = ST_DONE;
            ST_DONE: if (w_out_acc) w_state_nxt = ST_IDLE;
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready_o  = (r_state == ST_IDLE);
        out_valid_o = (r_state == ST_DONE);
    end

    // Final-edge result and flag selection from the complete sum/difference.
    always_comb begin
        w_fin   = w_full;
        w_c_fin = 1'b0;
        w_v_fin = 1'b0;
        case (r_op)
            ALU_ADD, ALU_SUB: begin
                w_c_fin = w_cout;
                w_v_fin = w_cout ^ w_cmsb;
            end
            ALU_SLT: begin
                w_fin    = '0;
                w_fin[0] = w_full[WIDTH-1] ^ (w_cout ^ w_cmsb);
                w_c_fin  = w_cout;
            end
            ALU_SLTU: begin
                w_fin    = '0;
                w_fin[0] = ~w_cout;
                w_c_fin  = w_cout;
            end
            ALU_RSVD: w_fin = '0;
            default:  ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_cy    <= 1'b0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
            r_neg   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid_i) begin
                        r_a   <= a_i;
                        r_b   <= b_i;
                        r_op  <= op_i;
                        r_cy  <= op_inverts_b(op_i);
                        r_cnt <= '0;
                    end
                end
                ST_BUSY: begin
                    r_a   <= r_a >> SLICE;
                    r_b   <= r_b >> SLICE;
                    r_cy  <= w_cout;
                    r_cnt <= r_cnt + c_cnt_w'(1);
                    if (w_last) begin
                        r_res   <= w_fin;
                        r_carry <= w_c_fin;
                        r_ovf   <= w_v_fin;
                        r_zero  <= (w_fin == '0);
                        r_neg   <= w_fin[WIDTH-1];
                    end else begin
                        r_res <= w_full;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result_o   = r_res;
    assign carry_o    = r_carry;
    assign overflow_o = r_ovf;
    assign zero_o     = r_zero;
    assign negative_o = r_neg;

endmodule

`default_nettype wire

// File: tb/tb_alu_serial.sv
// ============================================================================
// Module : tb_alu_serial
// Brief  : Directed self-checking bench for alu_serial (32/4 and 8/8 builds).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_alu_serial;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, result;
    logic [2:0]  op;
    logic        carry, ovf, zero, neg;

    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0]  a8, b8, result8;
    logic [2:0]  op8;
    logic        carry8, ovf8, zero8, neg8;

    int n_checks = 0;
    int n_errors = 0;
    int lat;

    always #5 clk = ~clk;

    alu_serial #(.WIDTH(32), .SLICE(4)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .a_i(a), .b_i(b), .op_i(op),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .result_o(result), .carry_o(carry), .overflow_o(ovf),
        .zero_o(zero), .negative_o(neg)
    );

    alu_serial #(.WIDTH(8), .SLICE(8)) dut8 (
        .clk_i(clk), .rst_n_i(rst_n),
        .in_valid_i(in_valid8), .in_ready_o(in_ready8),
        .a_i(a8), .b_i(b8), .op_i(op8),
        .out_valid_o(out_valid8), .out_ready_i(out_ready8),
        .result_o(result8), .carry_o(carry8), .overflow_o(ovf8),
        .zero_o(zero8), .negative_o(neg8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [31:0] r, input logic c,
                             input logic v, input logic z, input logic n);
        check({tag, ".result"}, result, r);
        check({tag, ".carry"},  carry,  c);
        check({tag, ".ovf"},    ovf,    v);
        check({tag, ".zero"},   zero,   z);
        check({tag, ".neg"},    neg,    n);
    endtask

    // Called #1 after an edge with the unit idle; returns edges from accept to out_valid.
    task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y);
        check({tag, ".in_ready"}, in_ready, 1'b1);
        in_valid = 1'b1; a = x; b = y; op = o;
        @(posedge clk); #1;
        in_valid = 1'b0; a = ~x; b = 32'h1234_5678; op = 3'd7;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, lat, 8);
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ".out_valid_drop"}, out_valid, 1'b0);
        check({tag, ".in_ready_back"},  in_ready,  1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not terminate");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 0; out_ready = 0; a = 0; b = 0; op = 0;
        in_valid8 = 0; out_ready8 = 0; a8 = 0; b8 = 0; op8 = 0;
        #3;
        check("rst.in_ready",  in_ready,  1'b1);
        check("rst.out_valid", out_valid, 1'b0);
        check_out("rst", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        do_op("add", 3'd2, 32'hFFFF_FFFF, 32'h0000_0001);
        check_out("add", 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        release_out("add");

        do_op("sub_ovf", 3'd3, 32'h8000_0000, 32'h0000_0001);
        check_out("sub_ovf", 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);
        release_out("sub_ovf");

        do_op("sub_neg", 3'd3, 32'h0000_0005, 32'h0000_0007);
        check_out("sub_neg", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1);
        release_out("sub_neg");

        do_op("slt", 3'd5, 32'hFFFF_FFFF, 32'h0000_0001);
        check_out("slt", 32'h1, 1'b1, 1'b0, 1'b0, 1'b0);
        release_out("slt");

        do_op("sltu", 3'd6, 32'hFFFF_FFFF, 32'h0000_0001);
        check_out("sltu", 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        release_out("sltu");

        do_op("xor", 3'd4, 32'hF0F0_F0F0, 32'hFFFF_0000);
        check_out("xor", 32'h0F0F_F0F0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; a = 32'(i); b = 32'h1; op = 3'd2;
            @(posedge clk); #1;
            check("hold.in_ready",  in_ready,  1'b0);
            check("hold.out_valid", out_valid, 1'b1);
            check("hold.result",    result,    32'h0F0F_F0F0);
        end
        in_valid = 1'b0;
        release_out("xor");
        check("xor.result_kept", result, 32'h0F0F_F0F0);

        do_op("rsvd", 3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check_out("rsvd", 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        release_out("rsvd");

        do_op("or", 3'd1, 32'h1234_5678, 32'h0F0F_0000);
        check_out("or", 32'h1F3F_5678, 1'b0, 1'b0, 1'b0, 1'b0);
        release_out("or");

        // Abort an op while slice 3 is being computed.
        in_valid = 1'b1; a = 32'h8000_0000; b = 32'h8000_0000; op = 3'd2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst.out_valid", out_valid, 1'b0);
        check("midrst.in_ready",  in_ready,  1'b1);
        check("midrst.result",    result,    32'h0);
        #2 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("midrst.no_result", out_valid, 1'b0);

        do_op("and", 3'd0, 32'hFF00_FF00, 32'h0FF0_0FF0);
        check_out("and", 32'h0F00_0F00, 1'b0, 1'b0, 1'b0, 1'b0);
        release_out("and");

        // Single-slice build: one BUSY cycle.
        check("w8.in_ready", in_ready8, 1'b1);
        in_valid8 = 1'b1; a8 = 8'h7F; b8 = 8'h01; op8 = 3'd2;
        @(posedge clk); #1;
        in_valid8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        lat = 0;
        while (!out_valid8 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check("w8.latency", lat, 1);
        check("w8.result", result8, 8'h80);
        check("w8.ovf",    ovf8,    1'b1);
        check("w8.neg",    neg8,    1'b1);
        check("w8.carry",  carry8,  1'b0);
        check("w8.zero",   zero8,   1'b0);
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
        check("w8.out_valid_drop", out_valid8, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
